// File: rtl/icache_resp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | icache_resp_pkg : shared types/constants for the icache responder  |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
package icache_resp_pkg;

  localparam int unsigned ICR_XLEN       = 32;
  localparam int unsigned ICR_DATA_W     = 32;
  localparam int unsigned ICR_LINE_WORDS = 4;

  // Byte-offset bits inside a line: word-index bits plus the 2 byte bits.
  function automatic int unsigned icr_off_w(input int unsigned line_words);
    return $clog2(line_words) + 2;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    RESP   = 2'd2
  } type_icresp_state_e;

  typedef struct packed {
    logic                req;
    logic [ICR_XLEN-1:0] addr;
  } type_icresp2mem_s;

  typedef struct packed {
    logic                  ack;
    logic [ICR_DATA_W-1:0] rdata;
  } type_mem2icresp_s;

endpackage : icache_resp_pkg
`default_nettype wire

// File: rtl/icache_line_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | icache_line_buf : one-line instruction store with tag/valid, write |
// |                   and read by word index                           |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module icache_line_buf
  import icache_resp_pkg::*;
#(
  parameter int XLEN       = ICR_XLEN,
  parameter int LINE_WORDS = ICR_LINE_WORDS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                we_i,
  input  logic [$clog2(LINE_WORDS)-1:0]       widx_i,
  input  logic [ICR_DATA_W-1:0]               wdata_i,
  input  logic [$clog2(LINE_WORDS)-1:0]       ridx_i,
  output logic [ICR_DATA_W-1:0]               rdata_o,
  input  logic                                tag_we_i,
  input  logic [XLEN-$clog2(LINE_WORDS)-3:0]  tag_i,
  input  logic                                valid_we_i,
  input  logic                                valid_i,
  input  logic [XLEN-$clog2(LINE_WORDS)-3:0]  lookup_tag_i,
  output logic                                hit_o
);

  localparam int TAG_W = XLEN - $clog2(LINE_WORDS) - 2;

  logic [ICR_DATA_W-1:0] line_q [LINE_WORDS];
  logic [ICR_DATA_W-1:0] line_d [LINE_WORDS];
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic                  valid_q, valid_d;

  always_comb begin
    for (int i = 0; i < LINE_WORDS; i++) begin
      line_d[i] = line_q[i];
    end
    if (we_i) begin
      line_d[widx_i] = wdata_i;
    end
    tag_d   = tag_we_i   ? tag_i   : tag_q;
    valid_d = valid_we_i ? valid_i : valid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        line_q[i] <= '0;
      end
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        line_q[i] <= line_d[i];
      end
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

  assign rdata_o = line_q[ridx_i];
  assign hit_o   = valid_q & (lookup_tag_i == tag_q);

endmodule : icache_line_buf
`default_nettype wire

// File: rtl/icache_line_resp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | icache_line_resp : single-line instruction cache responder; hits   |
// |                    in 1 cycle, misses refill the line word by word |
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
module icache_line_resp
  import icache_resp_pkg::*;
#(
  parameter int XLEN       = ICR_XLEN,
  parameter int LINE_WORDS = ICR_LINE_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [XLEN-1:0]       if_addr_i,
  input  logic                  if_kill_i,
  input  logic                  flush_i,
  output logic                  if_ack_o,
  output logic [ICR_DATA_W-1:0] if_rdata_o,
  output logic                  mem_req_o,
  output logic [XLEN-1:0]       mem_addr_o,
  input  logic                  mem_ack_i,
  input  logic [ICR_DATA_W-1:0] mem_rdata_i,
  output logic                  busy_o
);

  localparam int OFF_W = icr_off_w(LINE_WORDS);
  localparam int IDX_W = OFF_W - 2;
  localparam int TAG_W = XLEN - OFF_W;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

  type_icresp_state_e    state_q, state_d;
  logic [XLEN-1:0]       req_addr_q, req_addr_d;
  logic [IDX_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  drop_q, drop_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  ack_q, ack_d;
  logic [ICR_DATA_W-1:0] rdata_q, rdata_d;
  type_icresp2mem_s      mem_q, mem_d;
  type_mem2icresp_s      mem_in;

  logic                  buf_we;
  logic [IDX_W-1:0]      buf_ridx;
  logic [ICR_DATA_W-1:0] buf_rdata;
  logic                  buf_tag_we;
  logic                  buf_valid_we;
  logic                  buf_valid;
  logic                  buf_hit;

  logic                  accept;
  logic                  hit;
  logic                  last_beat;
  logic [TAG_W-1:0]      if_tag;
  logic [IDX_W-1:0]      if_idx;

  assign mem_in    = '{ack: mem_ack_i, rdata: mem_rdata_i};
  assign if_tag    = if_addr_i[XLEN-1:OFF_W];
  assign if_idx    = if_addr_i[OFF_W-1:2];
  assign accept    = if_req_i & ~if_kill_i;
  // A flush on the accept cycle invalidates the line first, so it cannot hit.
  assign hit       = buf_hit & ~flush_i;
  assign last_beat = mem_in.ack & (beat_cnt_q == LAST_BEAT);

  icache_line_buf #(
    .XLEN       (XLEN),
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buf (
    .clk          (clk),
    .rst          (rst),
    .we_i         (buf_we),
    .widx_i       (beat_cnt_q),
    .wdata_i      (mem_in.rdata),
    .ridx_i       (buf_ridx),
    .rdata_o      (buf_rdata),
    .tag_we_i     (buf_tag_we),
    .tag_i        (if_tag),
    .valid_we_i   (buf_valid_we),
    .valid_i      (buf_valid),
    .lookup_tag_i (if_tag),
    .hit_o        (buf_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      beat_cnt_q   <= '0;
      drop_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
      mem_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      beat_cnt_q   <= beat_cnt_d;
      drop_q       <= drop_d;
      flush_pend_q <= flush_pend_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      mem_q        <= mem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && !hit) state_d = REFILL;
      REFILL:  if (last_beat)      state_d = RESP;
      RESP:                        state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_comb begin
    req_addr_d   = req_addr_q;
    beat_cnt_d   = beat_cnt_q;
    drop_d       = drop_q;
    flush_pend_d = flush_pend_q;
    ack_d        = 1'b0;
    rdata_d      = rdata_q;
    mem_d        = mem_q;
    buf_we       = 1'b0;
    buf_ridx     = if_idx;
    buf_tag_we   = 1'b0;
    buf_valid_we = 1'b0;
    buf_valid    = 1'b0;

    unique case (state_q)
      IDLE: begin
        buf_valid_we = flush_i;
        if (accept) begin
          req_addr_d = if_addr_i;
          if (hit) begin
            ack_d   = 1'b1;
            rdata_d = buf_rdata;
          end else begin
            mem_d.req    = 1'b1;
            mem_d.addr   = {if_tag, {OFF_W{1'b0}}};
            beat_cnt_d   = '0;
            buf_valid_we = 1'b1;
            buf_tag_we   = 1'b1;
            drop_d       = 1'b0;
            flush_pend_d = 1'b0;
          end
        end
      end
      REFILL: begin
        // The memory port cannot abort, so kill/flush are only remembered.
        drop_d       = drop_q | if_kill_i;
        flush_pend_d = flush_pend_q | flush_i;
        if (mem_in.ack) begin
          buf_we     = 1'b1;
          beat_cnt_d = beat_cnt_q + IDX_W'(1);
        end
        if (last_beat) begin
          mem_d.req    = 1'b0;
          buf_valid_we = 1'b1;
          buf_valid    = ~(flush_pend_q | flush_i);
        end
      end
      RESP: begin
        buf_ridx     = req_addr_q[OFF_W-1:2];
        buf_valid_we = flush_i;
        if (!drop_q && !if_kill_i) begin
          ack_d   = 1'b1;
          rdata_d = buf_rdata;
        end
      end
      default: ;
    endcase
  end

  assign if_ack_o   = ack_q;
  assign if_rdata_o = rdata_q;
  assign mem_req_o  = mem_q.req;
  assign mem_addr_o = mem_q.addr;
  assign busy_o     = (state_q != IDLE);

endmodule : icache_line_resp
`default_nettype wire

// File: tb/tb_icache_line_resp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_icache_line_resp : directed self-checking bench for the icache  |
// | Revision            : 1.0                                          |
// +--------------------------------------------------------------------+
module tb_icache_line_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_kill_i;
  logic        flush_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  icache_line_resp dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_kill_i   (if_kill_i),
    .flush_i     (flush_i),
    .if_ack_o    (if_ack_o),
    .if_rdata_o  (if_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o)
  );

  // Advance one edge; outputs are then stable and inputs may change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d);
    mem_ack_i   = 1'b1;
    mem_rdata_i = d;
    step();
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h0000_1008;
    if_kill_i = 1'b0; flush_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({if_ack_o, mem_req_o, busy_o} !== 3'b000) $display("FAIL reset_outs cyc%0d: ack/req/busy=%b expected 000", i, {if_ack_o, mem_req_o, busy_o});
      else passed++;
    end
    total++;
    if ({if_rdata_o, mem_addr_o} !== 64'd0) $display("FAIL reset_data: rdata=%h addr=%h expected 0", if_rdata_o, mem_addr_o);
    else passed++;
    rst = 1'b0; if_req_i = 1'b0;
  endtask

  task automatic test_cold_miss();
    int lat;
    int nb;
    if_req_i = 1'b1; if_addr_i = 32'h0000_1008;
    step();
    if_req_i = 1'b0;
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_1000 || busy_o !== 1'b1)
      $display("FAIL cold_memreq: req=%b addr=%h busy=%b expected 1 00001000 1", mem_req_o, mem_addr_o, busy_o);
    else passed++;
    lat = 1; nb = 0;
    while (lat < 20) begin
      if (nb < 4) begin beat(32'hA0 + nb); nb++; end
      else step();
      lat++;
      if (if_ack_o) break;
    end
    total++;
    if (lat !== 6) $display("FAIL cold_latency: ack in cycle %0d expected 6", lat);
    else passed++;
    total++;
    if (if_ack_o !== 1'b1 || if_rdata_o !== 32'hA2) $display("FAIL cold_data: ack=%b rdata=%h expected 1 000000a2", if_ack_o, if_rdata_o);
    else passed++;
    step();
    total++;
    if (if_ack_o !== 1'b0 || if_rdata_o !== 32'hA2 || busy_o !== 1'b0)
      $display("FAIL cold_pulse: ack=%b rdata=%h busy=%b expected 0 000000a2 0", if_ack_o, if_rdata_o, busy_o);
    else passed++;
  endtask

  task automatic test_hits();
    logic [31:0] addrs [3];
    logic [31:0] exps  [3];
    addrs = '{32'h1000, 32'h1004, 32'h100C};
    exps  = '{32'hA0, 32'hA1, 32'hA3};
    for (int i = 0; i < 3; i++) begin
      if_req_i = 1'b1; if_addr_i = addrs[i];
      step();
      total++;
      if (if_ack_o !== 1'b1 || if_rdata_o !== exps[i] || mem_req_o !== 1'b0)
        $display("FAIL hit%0d: ack=%b rdata=%h mreq=%b expected 1 %h 0", i, if_ack_o, if_rdata_o, mem_req_o, exps[i]);
      else passed++;
    end
    if_req_i = 1'b0;
    step();
  endtask

  task automatic test_gaps();
    logic [6:0] pat;
    int nb;
    int early;
    logic [31:0] addrs [3];
    logic [31:0] exps  [3];
    pat = 7'b1101001;  // applied LSB first: 1,0,0,1,0,1,1
    if_req_i = 1'b1; if_addr_i = 32'h0000_2004;
    step();
    if_req_i = 1'b0;
    nb = 0; early = 0;
    for (int i = 0; i < 7; i++) begin
      if (pat[i]) begin beat(32'hB0 + nb); nb++; end
      else step();
      if (if_ack_o) early++;
    end
    total++;
    if (early !== 0 || mem_req_o !== 1'b0) $display("FAIL gaps_early: early_acks=%0d mreq=%b expected 0 0", early, mem_req_o);
    else passed++;
    step();
    total++;
    if (if_ack_o !== 1'b1 || if_rdata_o !== 32'hB1) $display("FAIL gaps_resp: ack=%b rdata=%h expected 1 000000b1", if_ack_o, if_rdata_o);
    else passed++;
    addrs = '{32'h2000, 32'h2008, 32'h200C};
    exps  = '{32'hB0, 32'hB2, 32'hB3};
    for (int i = 0; i < 3; i++) begin
      if_req_i = 1'b1; if_addr_i = addrs[i];
      step();
      total++;
      if (if_ack_o !== 1'b1 || if_rdata_o !== exps[i]) $display("FAIL gaps_word%0d: ack=%b rdata=%h expected 1 %h", i, if_ack_o, if_rdata_o, exps[i]);
      else passed++;
    end
    if_req_i = 1'b0;
    step();
  endtask

  task automatic test_kill();
    int acks;
    if_req_i = 1'b1; if_addr_i = 32'h0000_3008;
    step();
    if_req_i = 1'b0;
    beat(32'hC0);
    beat(32'hC1);
    if_kill_i = 1'b1;
    beat(32'hC2);
    if_kill_i = 1'b0;
    beat(32'hC3);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (if_ack_o) acks++;
    end
    total++;
    if (acks !== 0 || busy_o !== 1'b0) $display("FAIL kill_noack: acks=%0d busy=%b expected 0 0", acks, busy_o);
    else passed++;
    if_req_i = 1'b1; if_addr_i = 32'h0000_3008;
    step();
    if_req_i = 1'b0;
    total++;
    if (if_ack_o !== 1'b1 || if_rdata_o !== 32'hC2 || mem_req_o !== 1'b0)
      $display("FAIL kill_rehit: ack=%b rdata=%h mreq=%b expected 1 000000c2 0", if_ack_o, if_rdata_o, mem_req_o);
    else passed++;
    step();
  endtask

  task automatic test_flush();
    if_req_i = 1'b1; if_addr_i = 32'h0000_4000;
    step();
    if_req_i = 1'b0;
    beat(32'hD0);
    flush_i = 1'b1;
    beat(32'hD1);
    flush_i = 1'b0;
    beat(32'hD2);
    beat(32'hD3);
    step();
    total++;
    if (if_ack_o !== 1'b1 || if_rdata_o !== 32'hD0) $display("FAIL flush_resp: ack=%b rdata=%h expected 1 000000d0", if_ack_o, if_rdata_o);
    else passed++;
    if_req_i = 1'b1; if_addr_i = 32'h0000_4004;
    step();
    if_req_i = 1'b0;
    total++;
    if (if_ack_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_4000)
      $display("FAIL flush_refetch: ack=%b mreq=%b addr=%h expected 0 1 00004000", if_ack_o, mem_req_o, mem_addr_o);
    else passed++;
    for (int i = 0; i < 4; i++) beat(32'hE0 + i);
    step();
    total++;
    if (if_ack_o !== 1'b1 || if_rdata_o !== 32'hE1) $display("FAIL flush_refill: ack=%b rdata=%h expected 1 000000e1", if_ack_o, if_rdata_o);
    else passed++;
    // Line 0x4000 is valid now; a flush on the same cycle as a hit forces a miss.
    if_req_i = 1'b1; if_addr_i = 32'h0000_4008; flush_i = 1'b1;
    step();
    if_req_i = 1'b0; flush_i = 1'b0;
    total++;
    if (if_ack_o !== 1'b0 || mem_req_o !== 1'b1) $display("FAIL flush_idle_hit: ack=%b mreq=%b expected 0 1", if_ack_o, mem_req_o);
    else passed++;
    for (int i = 0; i < 4; i++) beat(32'hF0 + i);
    step();
    total++;
    if (if_ack_o !== 1'b1 || if_rdata_o !== 32'hF2) $display("FAIL flush_idle_refill: ack=%b rdata=%h expected 1 000000f2", if_ack_o, if_rdata_o);
    else passed++;
    step();
  endtask

  task automatic test_reset_mid_refill();
    if_req_i = 1'b1; if_addr_i = 32'h0000_5000;
    step();
    if_req_i = 1'b0;
    beat(32'h50);
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({if_ack_o, mem_req_o, busy_o} !== 3'b000) $display("FAIL rst_mid: ack/req/busy=%b expected 000", {if_ack_o, mem_req_o, busy_o});
    else passed++;
    if_req_i = 1'b1; if_addr_i = 32'h0000_1000;
    step();
    if_req_i = 1'b0;
    total++;
    if (if_ack_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_1000)
      $display("FAIL rst_invalid: ack=%b mreq=%b addr=%h expected 0 1 00001000", if_ack_o, mem_req_o, mem_addr_o);
    else passed++;
    for (int i = 0; i < 4; i++) beat(32'h60 + i);
    step();
    total++;
    if (if_ack_o !== 1'b1 || if_rdata_o !== 32'h60) $display("FAIL rst_refill: ack=%b rdata=%h expected 1 00000060", if_ack_o, if_rdata_o);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hits();
    test_gaps();
    test_kill();
    test_flush();
    test_reset_mid_refill();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_icache_line_resp
`default_nettype wire
